// File: rtl/leaf_stream_fifo.sv
// Single-clock valid/ready stream FIFO with registered occupancy.
// Outputs depend only on stored state, so no input reaches an output combinationally.
module leaf_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    cnt;
  logic             push, pop;

  assign full      = (cnt == LW'(DEPTH));
  assign empty     = (cnt == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = cnt;

  // A pop never frees space for a same-cycle push: in_ready comes from state only.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Zero the data bus while empty so stale storage is never exposed.
  assign out_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage has no reset; writes are still blocked during a reset cycle.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Directed bench for leaf_stream_fifo (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_leaf_stream_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, full, empty;
  logic [7:0] in_data, out_data;
  logic [2:0] level;
  int n_chk = 0;
  int n_err = 0;

  leaf_stream_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are state-only, so sampling 2 time units later is stable.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    step(); step();
    rst_n = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);

    // Latency: push in cycle N, visible in N+1.
    in_valid = 1'b1; in_data = 8'hA5;
    chk("lat_vld_n", 32'(out_valid), 0);
    step();
    in_valid = 1'b0; in_data = 8'hEE;
    chk("lat_vld_n1", 32'(out_valid), 1);
    chk("lat_data_n1", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat_drained", 32'(empty), 1);

    // Fill to full, then a fifth offer is ignored.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'((i + 1) * 8'h11);
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_in_ready", 32'(in_ready), 0);
    in_data = 8'h55;
    step();
    in_valid = 1'b0;
    chk("fill_5th_level", 32'(level), 4);
    chk("fill_head", 32'(out_data), 32'h11);

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(out_data), 32'((i + 1) * 8'h11));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_zero", 32'(out_data), 0);

    // Empty boundary: pop request with nothing stored changes nothing.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("empty_pop_level", 32'(level), 0);
    chk("empty_pop_data", 32'(out_data), 0);

    // Streaming at level 1 for 10 cycles; pointers wrap more than twice.
    in_valid = 1'b1; in_data = 8'h00;
    step();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data = 8'(k);
      chk("stream_data", 32'(out_data), 32'(k - 1));
      step();
      chk("stream_level", 32'(level), 1);
    end
    in_valid = 1'b0;
    chk("stream_last", 32'(out_data), 10);
    step();
    out_ready = 1'b0;
    chk("stream_empty", 32'(empty), 1);

    // Full boundary: offer plus pop at full -> level 3, offer dropped.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h21 + i);
      step();
    end
    chk("full2_full", 32'(full), 1);
    in_data = 8'h99; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_pop_level", 32'(level), 3);
    for (int i = 0; i < 3; i++) begin
      chk("full_pop_order", 32'(out_data), 32'(8'h22 + i));
      step();
    end
    out_ready = 1'b0;
    chk("full_pop_dropped", 32'(empty), 1);

    // Mid-operation reset at level 3 with an offer in the reset cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h31 + i);
      step();
    end
    chk("mrst_pre_level", 32'(level), 3);
    rst_n = 1'b0; in_data = 8'h77;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mrst_level", 32'(level), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    in_valid = 1'b1; in_data = 8'h66;
    step();
    in_valid = 1'b0;
    chk("mrst_resume_level", 32'(level), 1);
    chk("mrst_resume_data", 32'(out_data), 32'h66);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
endmodule
